// File: rtl/alu_pkg.sv
// Shared types for the ALU command front-end: widths, command struct, issuer FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

   localparam int ALU_DATA_W = 8;
   localparam int ALU_OP_W   = 5;
   localparam int ALU_STAT_W = 5;

   typedef struct packed {
      logic [ALU_OP_W-1:0]   op;
      logic [ALU_DATA_W-1:0] in1;
      logic [ALU_DATA_W-1:0] in2;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands, DEPTH entries (power of two), head shown combinationally.
// Latency: a pushed entry is visible at the head on the edge after the push.
// Backpressure: pushes while full and pops while empty are ignored; no pass-through when full.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  alu_cmd_t               push_cmd,
   input  logic                   pop,
   output alu_cmd_t               head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   alu_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array; stale entries are harmless because the pointers gate what is read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_cmd;
      end
   end

   // Pointers wrap naturally at DEPTH; occupancy holds on simultaneous push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers host commands, issues them one at a time to the ALU and returns result/status or a timeout.
// Latency: command accept to alu_enable 2 cycles when idle; alu_ready sampled at edge Ek gives rsp_valid from Ek.
// Backpressure: cmd_ready low only when the FIFO is full; a held response (rsp_ready low) stalls further issue.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ALU_OP_W-1:0]    cmd_op,
   input  logic [ALU_DATA_W-1:0]  cmd_in1,
   input  logic [ALU_DATA_W-1:0]  cmd_in2,
   output logic                   alu_enable,
   output logic [ALU_OP_W-1:0]    alu_op,
   output logic [ALU_DATA_W-1:0]  alu_in1,
   output logic [ALU_DATA_W-1:0]  alu_in2,
   input  logic                   alu_ready,
   input  logic [ALU_DATA_W-1:0]  alu_out,
   input  logic [ALU_STAT_W-1:0]  alu_status,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ALU_DATA_W-1:0]  rsp_data,
   output logic [ALU_STAT_W-1:0]  rsp_status,
   output logic                   rsp_timeout,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);

   localparam int TW = $clog2(TIMEOUT + 1);
   // Value the counter holds during the last WAIT cycle before expiry.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   issuer_state_e state;
   issuer_state_e state_nxt;
   alu_cmd_t      cmd_in;
   alu_cmd_t      head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          tmo_clr;
   logic          tmo_inc;
   logic          cap_alu;
   logic          cap_tmo;
   logic [TW-1:0] tmo_cnt;

   assign cmd_in    = '{op: cmd_op, in1: cmd_in1, in2: cmd_in2};
   assign cmd_ready = !fifo_full;

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (cmd_valid),
      .push_cmd (cmd_in),
      .pop      (pop),
      .head     (head),
      .count    (count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle strobes; alu_ready only matters in WAIT and beats expiry there.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      alu_enable = 1'b0;
      rsp_valid  = 1'b0;
      tmo_clr    = 1'b0;
      tmo_inc    = 1'b0;
      cap_alu    = 1'b0;
      cap_tmo    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_enable = 1'b1;
            tmo_clr    = 1'b1;
            state_nxt  = ST_WAIT;
         end
         ST_WAIT: begin
            if (alu_ready) begin
               cap_alu   = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               tmo_inc = 1'b1;
               if (tmo_cnt == TMO_LAST) begin
                  cap_tmo   = 1'b1;
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   // Operand registers change only on the pop edge and hold through ISSUE/WAIT/RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_op  <= '0;
         alu_in1 <= '0;
         alu_in2 <= '0;
      end else if (pop) begin
         alu_op  <= head.op;
         alu_in1 <= head.in1;
         alu_in2 <= head.in2;
      end
   end

   // Timeout counter: cleared at issue, counts silent WAIT cycles, saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (tmo_clr) begin
         tmo_cnt <= '0;
      end else if (tmo_inc && (tmo_cnt != '1)) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Response registers: loaded once when leaving WAIT, held stable through RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_data    <= '0;
         rsp_status  <= '0;
         rsp_timeout <= 1'b0;
      end else if (cap_alu) begin
         rsp_data    <= alu_out;
         rsp_status  <= alu_status;
         rsp_timeout <= 1'b0;
      end else if (cap_tmo) begin
         rsp_data    <= '0;
         rsp_status  <= '0;
         rsp_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed timing scenarios plus randomized traffic vs. an in-order reference.
// Latency: checks exact cycle positions of enable, response and timeout.
// Backpressure: exercises full FIFO, held responses and a stalled ALU.
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CW      = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [7:0] d;
      logic [4:0] s;
      logic       t;
   } rsp_t;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [4:0]    cmd_op;
   logic [7:0]    cmd_in1;
   logic [7:0]    cmd_in2;
   logic          alu_enable;
   logic [4:0]    alu_op;
   logic [7:0]    alu_in1;
   logic [7:0]    alu_in2;
   logic          alu_ready;
   logic [7:0]    alu_out;
   logic [4:0]    alu_status;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_data;
   logic [4:0]    rsp_status;
   logic          rsp_timeout;
   logic          busy;
   logic [CW-1:0] count;

   alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
      .alu_enable(alu_enable), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_ready(alu_ready), .alu_out(alu_out), .alu_status(alu_status),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
      .busy(busy), .count(count)
   );

   int checks;
   int errors;
   int en_cnt;

   alu_cmd_t host_q[$];
   alu_cmd_t push_q[$];
   alu_cmd_t iss_q[$];
   rsp_t     got_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural ALU: result is the byte sum, status mixes opcode with operand 1.
   function automatic logic [7:0] ref_out(input alu_cmd_t c);
      return c.in1 + c.in2;
   endfunction

   function automatic logic [4:0] ref_stat(input alu_cmd_t c);
      return c.op ^ c.in1[4:0];
   endfunction

   function automatic alu_cmd_t rand_cmd();
      alu_cmd_t c;
      c.op  = 5'($urandom_range(31));
      c.in1 = 8'($urandom_range(255));
      c.in2 = 8'($urandom_range(255));
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (alu_enable === 1'b1) en_cnt++;
   endtask

   task automatic drive_cmd(input alu_cmd_t c);
      cmd_op  = c.op;
      cmd_in1 = c.in1;
      cmd_in2 = c.in2;
   endtask

   task automatic clear_q();
      host_q.delete();
      push_q.delete();
      iss_q.delete();
      got_q.delete();
   endtask

   // Traffic engine: host feeds host_q, ALU answers lat cycles after enable, consumer takes responses.
   task automatic service(input int want, input int lat, input int rdy_pct, input int vld_pct,
                          input int max_cyc);
      int       cd;
      int       got;
      alu_cmd_t cur;
      cd  = 0;
      got = 0;
      cur = '0;
      for (int k = 0; k < max_cyc && got < want; k++) begin
         alu_ready  = 1'b0;
         alu_out    = 8'($urandom_range(255));
         alu_status = 5'($urandom_range(31));
         if (alu_enable) begin
            cur = '{op: alu_op, in1: alu_in1, in2: alu_in2};
            iss_q.push_back(cur);
            cd = lat;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               alu_ready  = 1'b1;
               alu_out    = ref_out(cur);
               alu_status = ref_stat(cur);
            end
         end
         rsp_ready = (int'($urandom_range(99)) < rdy_pct);
         if (rsp_valid && rsp_ready) begin
            got_q.push_back('{d: rsp_data, s: rsp_status, t: rsp_timeout});
            got++;
         end
         if (host_q.size() > 0 && (cmd_valid || int'($urandom_range(99)) < vld_pct)) begin
            cmd_valid = 1'b1;
            drive_cmd(host_q[0]);
            if (cmd_ready) push_q.push_back(host_q.pop_front());
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
      end
      cmd_valid = 1'b0;
      alu_ready = 1'b0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if (cmd_ready !== 1'b1 || count !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got ready=%b count=%0d busy=%b exp 1/0/0", cmd_ready, count, busy);
      end
      checks++;
      if (alu_enable !== 1'b0 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes got en=%b vld=%b tmo=%b exp 0/0/0", alu_enable, rsp_valid, rsp_timeout);
      end
      checks++;
      if ({alu_op, alu_in1, alu_in2, rsp_data, rsp_status} !== '0) begin
         errors++;
         $display("FAIL reset_data got op=%h in1=%h in2=%h data=%h stat=%h exp all 0",
                  alu_op, alu_in1, alu_in2, rsp_data, rsp_status);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      alu_cmd_t c;
      int       e0;
      c = '{op: 5'h01, in1: 8'h12, in2: 8'h34};
      drive_cmd(c);
      cmd_valid = 1'b1;
      tick();                       // E0: accepted
      cmd_valid = 1'b0;
      e0 = en_cnt;
      checks++;
      if (count !== CW'(1) || alu_enable !== 1'b0) begin
         errors++;
         $display("FAIL single_e0 got count=%0d en=%b exp 1/0", count, alu_enable);
      end
      tick();                       // E1: popped, ISSUE
      checks++;
      if (alu_enable !== 1'b1 || alu_op !== 5'h01 || alu_in1 !== 8'h12 || alu_in2 !== 8'h34) begin
         errors++;
         $display("FAIL single_issue got en=%b op=%h in1=%h in2=%h exp 1/01/12/34",
                  alu_enable, alu_op, alu_in1, alu_in2);
      end
      tick();                       // E2: WAIT
      tick();                       // E3
      checks++;
      if (rsp_valid !== 1'b0 || alu_enable !== 1'b0) begin
         errors++;
         $display("FAIL single_wait got vld=%b en=%b exp 0/0", rsp_valid, alu_enable);
      end
      alu_ready  = 1'b1;
      alu_out    = 8'h46;
      alu_status = 5'h00;
      tick();                       // E4: captured
      alu_ready = 1'b0;
      alu_out   = 8'hFF;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h46 || rsp_status !== 5'h00 || rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp got vld=%b data=%h stat=%h tmo=%b exp 1/46/00/0",
                  rsp_valid, rsp_data, rsp_status, rsp_timeout);
      end
      checks++;
      if (en_cnt - e0 != 1) begin
         errors++;
         $display("FAIL single_pulses got %0d enable pulses exp 1", en_cnt - e0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done got vld=%b busy=%b exp 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_fifo_full();
      alu_cmd_t c[6];
      clear_q();
      for (int i = 0; i < 6; i++) c[i] = rand_cmd();
      alu_ready = 1'b0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_cmd(c[i]);
         cmd_valid = 1'b1;
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_accept%0d got cmd_ready=%b exp 1", i, cmd_ready);
         end
         push_q.push_back(c[i]);
         tick();
         if (alu_enable) iss_q.push_back('{op: alu_op, in1: alu_in1, in2: alu_in2});
      end
      drive_cmd(c[5]);
      checks++;
      if (count !== CW'(4) || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_level got count=%0d ready=%b exp 4/0", count, cmd_ready);
      end
      repeat (2) tick();
      checks++;
      if (count !== CW'(4)) begin
         errors++;
         $display("FAIL full_refuse got count=%0d exp 4", count);
      end
      alu_ready  = 1'b1;
      alu_out    = ref_out(c[0]);
      alu_status = ref_stat(c[0]);
      tick();
      alu_ready = 1'b0;
      rsp_ready = 1'b1;
      if (rsp_valid) got_q.push_back('{d: rsp_data, s: rsp_status, t: rsp_timeout});
      tick();                       // response handshake, back to IDLE
      rsp_ready = 1'b0;
      checks++;
      if (count !== CW'(4) || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_idle got count=%0d ready=%b exp 4/0", count, cmd_ready);
      end
      tick();                       // pop edge: held push must be refused
      checks++;
      if (count !== CW'(3) || cmd_ready !== 1'b1 || alu_enable !== 1'b1 ||
          alu_op !== c[1].op || alu_in1 !== c[1].in1 || alu_in2 !== c[1].in2) begin
         errors++;
         $display("FAIL full_pop got count=%0d ready=%b en=%b op=%h in1=%h exp 3/1/1/%h/%h",
                  count, cmd_ready, alu_enable, alu_op, alu_in1, c[1].op, c[1].in1);
      end
      host_q.push_back(c[5]);
      service(5, int'($urandom_range(4, 1)), 100, 100, 1000);
      checks++;
      if (got_q.size() != 6 || iss_q.size() != 6 || push_q.size() != 6) begin
         errors++;
         $display("FAIL full_sizes got rsp=%0d iss=%0d push=%0d exp 6", got_q.size(), iss_q.size(),
                  push_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         checks++;
         if (got_q[i] !== rsp_t'{d: ref_out(c[i]), s: ref_stat(c[i]), t: 1'b0} || iss_q[i] !== c[i]) begin
            errors++;
            $display("FAIL full_order%0d got rsp=%h iss=%h exp rsp=%h iss=%h", i, got_q[i], iss_q[i],
                     rsp_t'{d: ref_out(c[i]), s: ref_stat(c[i]), t: 1'b0}, c[i]);
         end
      end
   endtask

   task automatic test_timeout();
      alu_cmd_t c;
      int       early;
      clear_q();
      c = rand_cmd();
      drive_cmd(c);
      cmd_valid = 1'b1;
      tick();                       // E0
      cmd_valid = 1'b0;
      tick();                       // E1 ISSUE
      tick();                       // E2 first WAIT cycle
      early = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         alu_out    = 8'($urandom_range(255, 1));
         alu_status = 5'($urandom_range(31, 1));
         tick();
         if (k < TIMEOUT && rsp_valid !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL tmo_early got %0d early valid cycles exp 0", early);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== 8'h00 || rsp_status !== 5'h00) begin
         errors++;
         $display("FAIL tmo_rsp got vld=%b tmo=%b data=%h stat=%h exp 1/1/00/00",
                  rsp_valid, rsp_timeout, rsp_data, rsp_status);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      c = rand_cmd();
      host_q.push_back(c);
      service(1, 2, 100, 100, 200);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== rsp_t'{d: ref_out(c), s: ref_stat(c), t: 1'b0}) begin
         errors++;
         $display("FAIL tmo_next got n=%0d rsp=%h exp 1/%h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : rsp_t'('0), rsp_t'{d: ref_out(c), s: ref_stat(c), t: 1'b0});
      end
   endtask

   task automatic test_expiry();
      alu_cmd_t c;
      c = rand_cmd();
      drive_cmd(c);
      cmd_valid = 1'b1;
      tick();                       // E0
      cmd_valid = 1'b0;
      tick();                       // E1 ISSUE: a ready here must be ignored
      alu_ready = 1'b1;
      alu_out   = 8'h3C;
      tick();                       // E2
      alu_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready got vld=%b busy=%b exp 0/1", rsp_valid, busy);
      end
      repeat (TIMEOUT - 1) tick();  // through WAIT cycle TIMEOUT-1
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL expiry_pre got vld=%b exp 0", rsp_valid);
      end
      alu_ready  = 1'b1;
      alu_out    = 8'hA5;
      alu_status = 5'h15;
      tick();                       // expiry cycle, ready wins
      alu_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_status !== 5'h15 || rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL expiry_rsp got vld=%b data=%h stat=%h tmo=%b exp 1/a5/15/0",
                  rsp_valid, rsp_data, rsp_status, rsp_timeout);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_rsp_hold();
      alu_cmd_t c0;
      alu_cmd_t c1;
      rsp_t     snap;
      int       e0;
      int       unstable;
      clear_q();
      c0 = rand_cmd();
      c1 = rand_cmd();
      cmd_valid = 1'b1;
      drive_cmd(c0);
      tick();                       // E0
      drive_cmd(c1);
      tick();                       // E1
      cmd_valid = 1'b0;
      tick();                       // E2 WAIT
      alu_ready  = 1'b1;
      alu_out    = 8'h5A;
      alu_status = 5'h0A;
      tick();                       // E3 RESP
      alu_ready = 1'b0;
      snap      = '{d: rsp_data, s: rsp_status, t: rsp_timeout};
      e0        = en_cnt;
      unstable  = 0;
      for (int k = 0; k < 10; k++) begin
         rsp_ready  = 1'b0;
         alu_ready  = k[0];
         alu_out    = 8'($urandom_range(255));
         alu_status = 5'($urandom_range(31));
         tick();
         if (rsp_valid !== 1'b1 || rsp_t'{d: rsp_data, s: rsp_status, t: rsp_timeout} !== snap) unstable++;
      end
      alu_ready = 1'b0;
      checks++;
      if (unstable != 0 || snap !== rsp_t'{d: 8'h5A, s: 5'h0A, t: 1'b0}) begin
         errors++;
         $display("FAIL hold_stable got %0d unstable cycles, rsp=%h exp 0 and 5a/0a/0", unstable, snap);
      end
      checks++;
      if (en_cnt != e0 || count !== CW'(1)) begin
         errors++;
         $display("FAIL hold_noissue got %0d extra enables count=%0d exp 0/1", en_cnt - e0, count);
      end
      rsp_ready = 1'b1;
      tick();                       // handshake edge
      rsp_ready = 1'b0;
      checks++;
      if (alu_enable !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap got en=%b vld=%b exp 0/0", alu_enable, rsp_valid);
      end
      tick();                       // next issue two cycles after handshake
      checks++;
      if (alu_enable !== 1'b1 || alu_op !== c1.op || alu_in1 !== c1.in1 || alu_in2 !== c1.in2) begin
         errors++;
         $display("FAIL b2b_issue got en=%b op=%h in1=%h in2=%h exp 1/%h/%h/%h",
                  alu_enable, alu_op, alu_in1, alu_in2, c1.op, c1.in1, c1.in2);
      end
      service(1, 1, 100, 100, 200);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== rsp_t'{d: ref_out(c1), s: ref_stat(c1), t: 1'b0}) begin
         errors++;
         $display("FAIL b2b_rsp got n=%0d exp 1 response %h", got_q.size(),
                  rsp_t'{d: ref_out(c1), s: ref_stat(c1), t: 1'b0});
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_cmd('{op: 5'(i + 3), in1: 8'hC0 + 8'(i), in2: 8'h0F});
         tick();
      end
      cmd_valid = 1'b0;
      checks++;
      if (count !== CW'(2) || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup got count=%0d busy=%b exp 2/1", count, busy);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (count !== '0 || busy !== 1'b0 || alu_enable !== 1'b0 || rsp_valid !== 1'b0 ||
          cmd_ready !== 1'b1 || alu_op !== '0 || alu_in1 !== '0) begin
         errors++;
         $display("FAIL mid_reset got count=%0d busy=%b en=%b vld=%b ready=%b op=%h in1=%h exp 0/0/0/0/1/0/0",
                  count, busy, alu_enable, rsp_valid, cmd_ready, alu_op, alu_in1);
      end
      reset = 1'b0;
      stray = 0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         alu_ready = 1'($urandom_range(1));
         alu_out   = 8'($urandom_range(255));
         tick();
         if (rsp_valid !== 1'b0 || alu_enable !== 1'b0 || busy !== 1'b0) stray++;
      end
      alu_ready = 1'b0;
      rsp_ready = 1'b0;
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL mid_dropped got %0d cycles with activity exp 0", stray);
      end
   endtask

   task automatic test_random();
      int n;
      clear_q();
      n = 0;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 12; i++) host_q.push_back(rand_cmd());
         n += 12;
         service(12, int'($urandom_range(TIMEOUT, 1)), int'($urandom_range(100, 30)),
                 int'($urandom_range(100, 30)), 3000);
      end
      checks++;
      if (push_q.size() != n || iss_q.size() != n || got_q.size() != n) begin
         errors++;
         $display("FAIL rand_sizes got push=%0d iss=%0d rsp=%0d exp %0d", push_q.size(), iss_q.size(),
                  got_q.size(), n);
      end
      for (int i = 0; i < got_q.size() && i < iss_q.size() && i < push_q.size(); i++) begin
         checks++;
         if (iss_q[i] !== push_q[i] ||
             got_q[i] !== rsp_t'{d: ref_out(push_q[i]), s: ref_stat(push_q[i]), t: 1'b0}) begin
            errors++;
            $display("FAIL rand_item%0d got iss=%h rsp=%h exp iss=%h rsp=%h", i, iss_q[i], got_q[i],
                     push_q[i], rsp_t'{d: ref_out(push_q[i]), s: ref_stat(push_q[i]), t: 1'b0});
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      en_cnt     = 0;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_in1    = '0;
      cmd_in2    = '0;
      alu_ready  = 1'b0;
      alu_out    = '0;
      alu_status = '0;
      rsp_ready  = 1'b0;
      test_reset();
      test_single();
      test_fifo_full();
      test_timeout();
      test_expiry();
      test_rsp_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
